// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Arbiter FSM states, latched memory operation, and port count.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT0  = 2'd1,
    GRANT1  = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

  localparam int ARB_PORTS = 2;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way picker: round-robin against `last`, or port 0
// wins ties when `fixed` is set.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [ARB_PORTS-1:0] req,
  input  logic                 last,
  input  logic                 fixed,
  output logic                 gnt_valid,
  output logic                 gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      // Tie: the port that did not win last time goes next.
      2'b11:   gnt_id = fixed ? 1'b0 : ~last;
      default: gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single memory port; bus driven from latched
// request registers. Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter bit FIXED_PRIO  = 1'b0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_be,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_resp,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_resp,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp,
  output logic                busy,
  output logic                grant_id,
  output logic                err,
  output arb_state_t          dbg_state
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t          state;
  logic                last_grant;
  mem_op_t             op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;

  logic [ARB_PORTS-1:0] req;
  logic                 gnt_valid;
  logic                 gnt_id;
  logic                 sel_write;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [BE_W-1:0]      sel_be;

  logic in_grant;
  logic done;
  logic to_hit;
  logic finish;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  rr_pick2 u_pick (
    .req       (req),
    .last      (last_grant),
    .fixed     (FIXED_PRIO),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // A write strobe wins over a simultaneous read strobe on the same port.
  assign sel_write = gnt_id ? m1_write : m0_write;
  assign sel_addr  = gnt_id ? m1_addr  : m0_addr;
  assign sel_wdata = gnt_id ? m1_wdata : m0_wdata;
  assign sel_be    = gnt_id ? m1_be    : m0_be;

  assign in_grant = (state == GRANT0) || (state == GRANT1);
  assign done     = in_grant && mem_resp;
  assign finish   = done || to_hit;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (!in_grant) begin
      to_cnt <= '0;
    end else if (!mem_resp && !to_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // A real response in the limit cycle is treated as normal completion.
  assign to_hit = in_grant && !mem_resp && (to_cnt == TO_LIM);
`else
  assign to_hit = 1'b0;
`endif

  assign err = to_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      busy       <= 1'b0;
      op_q       <= OP_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            state      <= gnt_id ? GRANT1 : GRANT0;
            last_grant <= gnt_id;
            grant_id   <= gnt_id;
            busy       <= 1'b1;
            op_q       <= sel_write ? OP_WRITE : OP_READ;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            be_q       <= sel_be;
          end
        end
        GRANT0, GRANT1: begin
          if (finish) begin
            state <= RELEASE;
            busy  <= 1'b0;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Bus strobes are qualified by the registered busy flag, so they drop
  // together with the grant.
  assign mem_read  = busy && (op_q == OP_READ);
  assign mem_write = busy && (op_q == OP_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

  assign m0_resp  = (state == GRANT0) && finish;
  assign m1_resp  = (state == GRANT1) && finish;
  assign m0_rdata = ((state == GRANT0) && mem_resp) ? mem_rdata : '0;
  assign m1_rdata = ((state == GRANT1) && mem_resp) ? mem_rdata : '0;

  assign dbg_state = state;

  a_resp_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    !(m0_resp && m1_resp));

  a_bus_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (in_grant && ($past(state) == state)) |->
      ($stable(mem_addr) && $stable(mem_wdata) && $stable(mem_be)));

  a_busy_state : assert property (@(posedge clk) disable iff (!rst_n)
    busy == in_grant);

  a_err_in_grant : assert property (@(posedge clk) disable iff (!rst_n)
    err |-> (in_grant && (TIMEOUT_CYC > 0)));

endmodule
